// File: rtl/overcooked_pkg.sv
// rtl/overcooked_pkg.sv - shared game-logic constants, sprite indices and pot state types
package overcooked_pkg;

  localparam logic [7:0] KEY_E        = 8'h08;
  localparam logic [3:0] TILE_COUNTER = 4'd1;
  localparam logic [3:0] TILE_STOVE   = 4'd3;
  localparam logic [3:0] TILE_VENT    = 4'd8;

  localparam logic [2:0] SPR_NONE  = 3'd0;
  localparam logic [2:0] SPR_ONION = 3'd1;
  localparam logic [2:0] SPR_PLATE = 3'd2;

  localparam logic [1:0] PLATE_EMPTY = 2'd0;

  typedef enum logic [1:0] {
    POT_EMPTY   = 2'd0,
    POT_READY   = 2'd1,
    POT_COOKING = 2'd2,
    POT_BURNT   = 2'd3
  } pot_state_t;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_FILLING,
    S_COOKING,
    S_DONE,
    S_BURNT
  } pot_fsm_t;

  function automatic pot_state_t pot_state_of(input pot_fsm_t s);
    case (s)
      S_COOKING: pot_state_of = POT_COOKING;
      S_DONE:    pot_state_of = POT_READY;
      S_BURNT:   pot_state_of = POT_BURNT;
      default:   pot_state_of = POT_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-frame key debounce: accepts one press after >= 3 idle frames
module key_debounce
  import overcooked_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_E
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_keycode,
  output logic       o_accept
);

  logic [3:0] r_count;
  logic       w_is_key;

  assign w_is_key = (i_keycode == KEY);
  assign o_accept = w_is_key && (r_count >= 4'd3);

  // Holding the key leaves the counter at 0, so only the first frame of a hold is accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 4'd0;
    end else if (!w_is_key) begin
      if (r_count != 4'hF) r_count <= r_count + 4'd1;
    end else if (o_accept) begin
      r_count <= 4'd0;
    end
  end

endmodule

// File: rtl/stove_pot.sv
// rtl/stove_pot.sv - stove pot: onion deposits, cook timer, soup handoff to plate
// Optional burning of uncollected soup is enabled by defining POT_BURN_EN.
module stove_pot #(
  parameter int ONIONS_PER_SOUP = 3,
  parameter int COOK_FRAMES     = 300,
  parameter int BURN_FRAMES     = 600
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       wallFlag,
  input  logic [3:0] tileType,
  input  logic [2:0] spriteIndexIn,
  input  logic [1:0] plateState,
  output logic [1:0] potState,
  output logic [1:0] onionCount,
  output logic [9:0] cookTimer,
  output logic       onionConsumed,
  output logic       soupTaken
);
  import overcooked_pkg::*;

  if (ONIONS_PER_SOUP < 1 || ONIONS_PER_SOUP > 3 || COOK_FRAMES < 1 || COOK_FRAMES > 1023 ||
      BURN_FRAMES < 1 || BURN_FRAMES > 1023) begin : g_bad_params
    $error("stove_pot: parameter out of range");
  end

  localparam logic [1:0] LP_ONIONS    = 2'(ONIONS_PER_SOUP);
  localparam logic [9:0] LP_COOK_LAST = 10'(COOK_FRAMES - 1);
`ifdef POT_BURN_EN
  localparam logic [9:0] LP_BURN_LAST = 10'(BURN_FRAMES - 1);
`endif

  pot_fsm_t   r_state, w_state_next;
  pot_state_t r_pot_state;
  logic [1:0] r_onion_count, w_onion_count_next;
  logic [9:0] r_cook_timer, w_cook_timer_next;
  logic       r_onion_consumed, w_onion_consumed_next;
  logic       r_soup_taken, w_soup_taken_next;
  logic       w_accept;
  logic       w_interact;

  key_debounce #(.KEY(KEY_E)) u_debounce (
    .i_clk     (frame_clk),
    .i_reset   (Reset),
    .i_keycode (keycode),
    .o_accept  (w_accept)
  );

  assign w_interact = w_accept && wallFlag && (tileType == TILE_STOVE);

  always_comb begin
    w_state_next          = r_state;
    w_onion_count_next    = r_onion_count;
    w_cook_timer_next     = r_cook_timer;
    w_onion_consumed_next = 1'b0;
    w_soup_taken_next     = 1'b0;
    case (r_state)
      S_EMPTY, S_FILLING: begin
        if (w_interact && spriteIndexIn == SPR_ONION) begin
          w_onion_count_next    = r_onion_count + 2'd1;
          w_onion_consumed_next = 1'b1;
          if (w_onion_count_next == LP_ONIONS) begin
            w_state_next      = S_COOKING;
            w_cook_timer_next = 10'd0;
          end else begin
            w_state_next = S_FILLING;
          end
        end
      end
      S_COOKING: begin
        if (r_cook_timer == LP_COOK_LAST) begin
          w_state_next      = S_DONE;
          w_cook_timer_next = 10'd0;
        end else begin
          w_cook_timer_next = r_cook_timer + 10'd1;
        end
      end
      S_DONE: begin
        // A pickup on the burn frame still delivers the soup.
        if (w_interact && spriteIndexIn == SPR_PLATE && plateState == PLATE_EMPTY) begin
          w_soup_taken_next  = 1'b1;
          w_state_next       = S_EMPTY;
          w_onion_count_next = 2'd0;
          w_cook_timer_next  = 10'd0;
        end
`ifdef POT_BURN_EN
        else if (r_cook_timer == LP_BURN_LAST) begin
          w_state_next      = S_BURNT;
          w_cook_timer_next = 10'd0;
        end else begin
          w_cook_timer_next = r_cook_timer + 10'd1;
        end
`endif
      end
`ifdef POT_BURN_EN
      S_BURNT: begin
        if (w_interact && (spriteIndexIn == SPR_NONE || spriteIndexIn == SPR_PLATE)) begin
          w_state_next       = S_EMPTY;
          w_onion_count_next = 2'd0;
        end
      end
`endif
      default: begin
        w_state_next       = S_EMPTY;
        w_onion_count_next = 2'd0;
        w_cook_timer_next  = 10'd0;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state          <= S_EMPTY;
      r_pot_state      <= POT_EMPTY;
      r_onion_count    <= 2'd0;
      r_cook_timer     <= 10'd0;
      r_onion_consumed <= 1'b0;
      r_soup_taken     <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_pot_state      <= pot_state_of(w_state_next);
      r_onion_count    <= w_onion_count_next;
      r_cook_timer     <= w_cook_timer_next;
      r_onion_consumed <= w_onion_consumed_next;
      r_soup_taken     <= w_soup_taken_next;
    end
  end

  assign potState      = r_pot_state;
  assign onionCount    = r_onion_count;
  assign cookTimer     = r_cook_timer;
  assign onionConsumed = r_onion_consumed;
  assign soupTaken     = r_soup_taken;

endmodule

// File: tb/tb_stove_pot.sv
// tb/tb_stove_pot.sv - scoreboard bench for stove_pot against a frame-level pot model
module tb_stove_pot;

  localparam int OPS  = 3;
  localparam int COOK = 300;
  localparam int BURN = 600;
`ifdef POT_BURN_EN
  localparam bit BURN_ON = 1'b1;
`else
  localparam bit BURN_ON = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       wallFlag = 1'b0;
  logic [3:0] tileType = 4'd0;
  logic [2:0] spriteIndexIn = 3'd0;
  logic [1:0] plateState = 2'd0;
  logic [1:0] potState;
  logic [1:0] onionCount;
  logic [9:0] cookTimer;
  logic       onionConsumed;
  logic       soupTaken;

  stove_pot dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .wallFlag      (wallFlag),
    .tileType      (tileType),
    .spriteIndexIn (spriteIndexIn),
    .plateState    (plateState),
    .potState      (potState),
    .onionCount    (onionCount),
    .cookTimer     (cookTimer),
    .onionConsumed (onionConsumed),
    .soupTaken     (soupTaken)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [1:0] pot;
    logic [1:0] cnt;
    logic [9:0] tmr;
    logic       oc;
    logic       st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  // Model: phase 0 = empty/filling, 1 = cooking, 2 = soup ready, 3 = burnt.
  int m_idle_frames = 0;
  int m_onions = 0;
  int m_phase = 0;
  int m_age = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at frame %0d: got %0d, expected %0d", name, frame_no, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] key, input logic wall,
                      input logic [3:0] tile, input logic [2:0] spr, input logic [1:0] plate);
    exp_t e;
    bit   acc;
    bit   inter;
    int   tmr;
    @(negedge frame_clk);
    Reset = rst;
    keycode = key;
    wallFlag = wall;
    tileType = tile;
    spriteIndexIn = spr;
    plateState = plate;
    e.oc = 1'b0;
    e.st = 1'b0;
    if (rst) begin
      m_idle_frames = 0;
      m_onions = 0;
      m_phase = 0;
      m_age = 0;
    end else begin
      acc = (key == 8'h08) && (m_idle_frames >= 3);
      if (key != 8'h08) m_idle_frames++;
      else if (acc) m_idle_frames = 0;
      inter = acc && wall && (tile == 4'd3);
      case (m_phase)
        0: if (inter && spr == 3'd1) begin
          m_onions++;
          e.oc = 1'b1;
          if (m_onions == OPS) begin
            m_phase = 1;
            m_age = 0;
          end
        end
        1: begin
          m_age++;
          if (m_age == COOK) begin
            m_phase = 2;
            m_age = 0;
          end
        end
        2: if (inter && spr == 3'd2 && plate == 2'd0) begin
          e.st = 1'b1;
          m_phase = 0;
          m_onions = 0;
          m_age = 0;
        end else if (BURN_ON) begin
          m_age++;
          if (m_age == BURN) begin
            m_phase = 3;
            m_age = 0;
          end
        end
        default: if (inter && (spr == 3'd0 || spr == 3'd2)) begin
          m_phase = 0;
          m_onions = 0;
        end
      endcase
    end
    case (m_phase)
      1: e.pot = 2'd2;
      2: e.pot = 2'd1;
      3: e.pot = 2'd3;
      default: e.pot = 2'd0;
    endcase
    tmr = (m_phase == 1 || (m_phase == 2 && BURN_ON)) ? m_age : 0;
    e.cnt = 2'(m_onions);
    e.tmr = 10'(tmr);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 2'd0);
  endtask

  task automatic press(input logic [2:0] spr, input logic [1:0] plate);
    step(1'b0, 8'h08, 1'b1, 4'd3, spr, plate);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        frame_no++;
        chk("potState", int'(potState), int'(e.pot));
        chk("onionCount", int'(onionCount), int'(e.cnt));
        chk("cookTimer", int'(cookTimer), int'(e.tmr));
        chk("onionConsumed", int'(onionConsumed), int'(e.oc));
        chk("soupTaken", int'(soupTaken), int'(e.st));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    step(1'b1, 8'h00, 1'b0, 4'd0, 3'd0, 2'd0);
    step(1'b1, 8'h00, 1'b0, 4'd0, 3'd0, 2'd0);
    idle(5);
    for (int i = 0; i < 3; i++) begin
      press(3'd1, 2'd0);
      idle(3);
    end
    idle(300);
    press(3'd2, 2'd1);
    idle(3);
    press(3'd2, 2'd0);
    idle(3);
    for (int i = 0; i < 10; i++) press(3'd1, 2'd0);
    idle(3);
    step(1'b0, 8'h08, 1'b1, 4'd1, 3'd1, 2'd0);
    idle(3);
    press(3'd1, 2'd0);
    idle(3);
    press(3'd1, 2'd0);
    idle(3);
    press(3'd1, 2'd0);
    idle(3);
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom_range(0, 255)), 1'b1, 4'd3, 3'd1, 2'd0);
    idle(300);
    idle(610);
    press(3'd0, 2'd0);
    idle(3);
    press(3'd2, 2'd0);
    idle(3);
    step(1'b1, 8'h08, 1'b1, 4'd3, 3'd1, 2'd0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 499) == 0),
           ($urandom_range(0, 2) == 0) ? 8'h08 : 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0) ? 4'd3 : 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 2)),
           2'($urandom_range(0, 1)));
    end
    idle(2);
    @(posedge frame_clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stove_pot.md
# stove_pot

Stove-side responder to the plate/onion carry protocol. Tracks onion deposits and cook progress and publishes `potState` to the plate entity, which samples it when the penguin presses E at the stove. Sits beside `plate` in the game-logic layer and is clocked once per frame by vsync. It issues one-frame acknowledge pulses so the carried-item entities can respawn or change state.

## Interface

Parameters:
- `ONIONS_PER_SOUP`, default 3: onions required to start cooking (1..3).
- `COOK_FRAMES`, default 300: frames from cook start to soup ready (1..1023).
- `BURN_FRAMES`, default 600: frames soup may sit before burning (1..1023; used only with the burn feature).

Ports:
- `frame_clk`  in  1  vsync frame clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `keycode`  in  8  current USB keycode; `8'h08` is E.
- `wallFlag`  in  1  penguin is touching a wall tile.
- `tileType`  in  4  tile type adjacent to the penguin; 3 is the stove.
- `spriteIndexIn`  in  3  item the penguin holds: 0 none, 1 onion, 2 plate.
- `plateState`  in  2  held plate contents: 0 empty, 1 onion soup.
- `potState`  out  2  0 empty/filling, 1 soup ready, 2 cooking, 3 burnt.
- `onionCount`  out  2  onions currently in the pot.
- `cookTimer`  out  10  frame counter for the progress bar; 0 when not cooking or ready.
- `onionConsumed`  out  1  one-frame pulse: the held onion was deposited.
- `soupTaken`  out  1  one-frame pulse: the soup was transferred to the plate.

## Operation

- Debounce: a 4-bit counter increments and saturates at 15 on every frame with `keycode != 8'h08`. A press is **accepted** on a frame with `keycode == 8'h08` and counter >= 3; that frame clears the counter. Holding E therefore yields exactly one accept.
- Interaction = accepted press AND `wallFlag` AND `tileType == 3`. Accepted presses elsewhere only clear the debounce counter.
- States: EMPTY, FILLING, COOKING, DONE, and BURNT (BURNT only with the burn feature).
  - **EMPTY/FILLING**, interaction with `spriteIndexIn == 1`:
    - `onionCount` increments and `onionConsumed` pulses.
    - If the new count equals `ONIONS_PER_SOUP`, go to COOKING with `cookTimer` = 0. Otherwise go to (or stay in) FILLING.
    - Any other held item is ignored.
  - **COOKING**:
    - All interactions are ignored.
    - `cookTimer` increments each frame.
    - On the frame `cookTimer == COOK_FRAMES-1`, go to DONE and set `cookTimer` to 0.
  - **DONE**, interaction with `spriteIndexIn == 2` and `plateState == 0`:
    - `soupTaken` pulses.
    - Go to EMPTY and clear `onionCount`.
    - A full plate, an onion, or empty hands are ignored.
- `potState` encoding: 0 in EMPTY and FILLING, 2 in COOKING, 1 in DONE, 3 in BURNT.
- Boundaries:
  - `onionCount` never exceeds `ONIONS_PER_SOUP`.
  - A keycode change mid-cook has no effect.
  - Reset in any state discards the contents.

## Timing

- All outputs are registered. Reset values:
  - `potState` = 0, `onionCount` = 0, `cookTimer` = 0.
  - `onionConsumed` = 0, `soupTaken` = 0.
  - State = EMPTY; debounce counter = 0.
- Deposit or pickup effects are visible on the edge that ends the accepting frame; the pulses are high for exactly that one frame.
- Soup handoff: the plate samples `potState == 1` during the same accepting frame. On that edge the plate sets `plateState` to 1 while the pot drops to 0, so both sides agree without an extra cycle.
- Soup is ready exactly `COOK_FRAMES` edges after the edge that entered COOKING.
- If Reset is asserted with an accepted press in the same frame, Reset wins.

## Configuration

- `POT_BURN_EN` defined:
  - In DONE, `cookTimer` counts frames; on `cookTimer == BURN_FRAMES-1` the pot goes to BURNT (`potState` = 3) with `cookTimer` = 0.
  - BURNT clears to EMPTY on an interaction with `spriteIndexIn` equal to 0 or 2. `soupTaken` does not pulse and the plate stays empty.
- `POT_BURN_EN` undefined: DONE holds indefinitely, `cookTimer` stays 0 in DONE, and `potState` is never 3.

## Structure

- Shared package `overcooked_pkg`:
  - Constants `KEY_E` = 8'h08, `TILE_COUNTER` = 1, `TILE_STOVE` = 3, `TILE_VENT` = 8.
  - Sprite indices `SPR_NONE`/`SPR_ONION`/`SPR_PLATE` = 0/1/2.
  - `pot_state_t` (2-bit potState encoding) and the pot FSM state enum.
- Sub-module `key_debounce`: saturating frame counter plus accept pulse for one keycode. It is reusable by the plate and onion entities.

## Test plan

- Reset, then idle 5 frames -> all outputs 0, state EMPTY.
- Three separated E presses at the stove (`wallFlag` = 1, `tileType` = 3, holding onion), with 3 non-E frames between presses -> three `onionConsumed` pulses, `onionCount` goes 1,2,3, and `potState` = 2 after the third press. Ready `potState` = 1 arrives exactly 300 frames later.
- E held for 10 frames with an onion -> exactly one deposit, `onionCount` = 1.
- Pot DONE, E with plate and `plateState` = 1 -> ignored. Then `plateState` = 0 -> `soupTaken` pulse, `potState` = 0, `onionCount` = 0.
- E with an onion while COOKING, or with `tileType` = 1 -> no pulse, no state change.
- With `POT_BURN_EN` and `BURN_FRAMES` = 600: DONE left 600 frames -> `potState` = 3. E with empty hands -> EMPTY, no `soupTaken`. Without the macro -> `potState` stays 1.
